// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full adder with a registered carry,
// processing one operand bit per enabled clock, LSB first.
// Subtraction is a + ~b + 1, so the carry is preloaded with the mode bit.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_reg;
  state_t             state_next;
  logic [WIDTH-1:0]   op_a_reg;
  logic [WIDTH-1:0]   op_b_reg;
  logic [WIDTH-1:0]   shadow_reg;
  logic               carry_reg;
  logic [CNT_W-1:0]   count_reg;

  logic               bit_s;
  logic               carry_next;
  logic               last_bit;
  logic               accept;

  // Full adder on the current LSBs; the last bit is the WIDTH-th processed
  assign bit_s      = op_a_reg[0] ^ op_b_reg[0] ^ carry_reg;
  assign carry_next = (op_a_reg[0] & op_b_reg[0]) |
                      (op_a_reg[0] & carry_reg)   |
                      (op_b_reg[0] & carry_reg);
  assign last_bit   = (count_reg == CNT_W'(WIDTH - 1));
  assign accept     = ena && start && (state_reg != RUN);

  assign busy = (state_reg == RUN);
  assign done = (state_reg == DONE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; nothing moves while ena is low
  always_comb begin
    state_next = state_reg;
    if (ena) begin
      case (state_reg)
        IDLE:    if (start) state_next = RUN;
        RUN:     if (last_bit) state_next = DONE;
        DONE:    state_next = start ? RUN : IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Operand shift registers, carry, bit counter and shadow sum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_reg   <= '0;
      op_b_reg   <= '0;
      shadow_reg <= '0;
      carry_reg  <= 1'b0;
      count_reg  <= '0;
    end else if (ena) begin
      if (accept) begin
        op_a_reg  <= a;
        op_b_reg  <= sub ? ~b : b;
        carry_reg <= sub;
        count_reg <= '0;
      end else if (state_reg == RUN) begin
        shadow_reg <= {bit_s, shadow_reg[WIDTH-1:1]};
        op_a_reg   <= op_a_reg >> 1;
        op_b_reg   <= op_b_reg >> 1;
        carry_reg  <= carry_next;
        // Counter stops at WIDTH-1; the state change ends the run there
        if (!last_bit) begin
          count_reg <= count_reg + CNT_W'(1);
        end
      end
    end
  end

  // Result registers: updated only when the final bit completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else if (ena && (state_reg == RUN) && last_bit) begin
      sum  <= {bit_s, shadow_reg[WIDTH-1:1]};
      cout <= carry_next;
      // carry_reg here is the carry into the MSB
      ovf  <= carry_reg ^ carry_next;
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: hand-computed vector table on an
// 8-bit instance, multi-cycle corner sequences, and back-to-back chains on
// 2-, 8- and 32-bit instances against a signed/unsigned arithmetic model.
module tb_serial_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic ena;

  // Inputs per instance: 0 = WIDTH 8, 1 = WIDTH 2, 2 = WIDTH 32
  logic        start_w [3];
  logic        sub_w   [3];
  logic [31:0] a_w     [3];
  logic [31:0] b_w     [3];

  logic        busy8, done8, cout8, ovf8;
  logic [7:0]  sum8;
  logic        busy2, done2, cout2, ovf2;
  logic [1:0]  sum2;
  logic        busy32, done32, cout32, ovf32;
  logic [31:0] sum32;

  serial_addsub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start_w[0]), .sub(sub_w[0]),
    .a(a_w[0][7:0]), .b(b_w[0][7:0]), .busy(busy8), .done(done8),
    .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_addsub #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start_w[1]), .sub(sub_w[1]),
    .a(a_w[1][1:0]), .b(b_w[1][1:0]), .busy(busy2), .done(done2),
    .sum(sum2), .cout(cout2), .ovf(ovf2)
  );

  serial_addsub #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start_w[2]), .sub(sub_w[2]),
    .a(a_w[2]), .b(b_w[2]), .busy(busy32), .done(done32),
    .sum(sum32), .cout(cout32), .ovf(ovf32)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       s;
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] e_sum;
    logic       e_cout;
    logic       e_ovf;
  } vec8_t;

  typedef struct {
    logic        s;
    logic [31:0] x;
    logic [31:0] y;
  } op_t;

  op_t chain_q[$];

  function automatic int wid(input int i);
    case (i)
      0:       return 8;
      1:       return 2;
      default: return 32;
    endcase
  endfunction

  function automatic logic [31:0] f_sum(input int i);
    case (i)
      0:       return {24'b0, sum8};
      1:       return {30'b0, sum2};
      default: return sum32;
    endcase
  endfunction

  function automatic logic f_done(input int i);
    case (i)
      0:       return done8;
      1:       return done2;
      default: return done32;
    endcase
  endfunction

  function automatic logic f_busy(input int i);
    case (i)
      0:       return busy8;
      1:       return busy2;
      default: return busy32;
    endcase
  endfunction

  function automatic logic f_cout(input int i);
    case (i)
      0:       return cout8;
      1:       return cout2;
      default: return cout32;
    endcase
  endfunction

  function automatic logic f_ovf(input int i);
    case (i)
      0:       return ovf8;
      1:       return ovf2;
      default: return ovf32;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Arithmetic reference: unsigned result/carry and signed range test
  task automatic ref_model(input int w, input logic s, input logic [31:0] x,
                           input logic [31:0] y, output logic [31:0] rs,
                           output logic rc, output logic ro);
    longint m, half, ux, uy, sx, sy, r, t;
    m    = (longint'(1) << w) - 1;
    half = (m + 1) / 2;
    ux   = longint'({32'b0, x}) & m;
    uy   = longint'({32'b0, y}) & m;
    sx   = (ux >= half) ? ux - (m + 1) : ux;
    sy   = (uy >= half) ? uy - (m + 1) : uy;
    if (s) begin
      r  = sx - sy;
      t  = (ux - uy) & m;
      rc = (ux >= uy);
    end else begin
      r  = sx + sy;
      t  = (ux + uy) & m;
      rc = ((ux + uy) > m);
    end
    rs = t[31:0];
    ro = (r > half - 1) || (r < -half);
  endtask

  // Called just after a negedge; returns just after the negedge following E0.
  // Inputs are scrambled after E0 to show they are not re-sampled.
  task automatic launch(input int i, input logic s, input logic [31:0] x, input logic [31:0] y);
    start_w[i] = 1'b1;
    sub_w[i]   = s;
    a_w[i]     = x;
    b_w[i]     = y;
    @(negedge clk);
    start_w[i] = 1'b0;
    sub_w[i]   = 1'($urandom_range(0, 1));
    a_w[i]     = $urandom;
    b_w[i]     = $urandom;
  endtask

  // Counts negedges until done is seen, bounded
  task automatic wait_done(input int i, output int cnt);
    cnt = 0;
    while (!f_done(i) && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  // Runs chain_q back to back on instance i: each new start is issued in the DONE cycle
  task automatic run_chain(input int i);
    int          cnt;
    int          n;
    logic [31:0] rs;
    logic        rc, ro;
    n = chain_q.size();
    @(negedge clk);
    launch(i, chain_q[0].s, chain_q[0].x, chain_q[0].y);
    for (int k = 0; k < n; k++) begin
      wait_done(i, cnt);
      chk($sformatf("w%0d_latency_%0d", wid(i), k), cnt, wid(i));
      ref_model(wid(i), chain_q[k].s, chain_q[k].x, chain_q[k].y, rs, rc, ro);
      chk($sformatf("w%0d_sum_%0d", wid(i), k), f_sum(i), rs);
      chk($sformatf("w%0d_cout_%0d", wid(i), k), f_cout(i), rc);
      chk($sformatf("w%0d_ovf_%0d", wid(i), k), f_ovf(i), ro);
      $display("w%0d op %0d sub=%0d a=0x%0h b=0x%0h -> sum=0x%0h cout=%0d ovf=%0d cycles=%0d",
               wid(i), k, chain_q[k].s, chain_q[k].x, chain_q[k].y, f_sum(i), f_cout(i), f_ovf(i), cnt);
      if (k < n - 1) begin
        launch(i, chain_q[k+1].s, chain_q[k+1].x, chain_q[k+1].y);
        chk($sformatf("w%0d_b2b_done_drop_%0d", wid(i), k), f_done(i), 1'b0);
        chk($sformatf("w%0d_b2b_busy_%0d", wid(i), k), f_busy(i), 1'b1);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec8_t       tbl[10];
    int          cnt;
    int          extra;
    int          seen;
    op_t         op;

    tbl[0] = '{1'b0, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
    tbl[3] = '{1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
    tbl[9] = '{1'b1, 8'h7F, 8'hFF, 8'h80, 1'b0, 1'b1};

    rst_n = 1'b0;
    ena   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_w[i] = 1'b0;
      sub_w[i]   = 1'b0;
      a_w[i]     = '0;
      b_w[i]     = '0;
    end
    repeat (2) @(negedge clk);
    chk("reset_busy", busy8, 1'b0);
    chk("reset_done", done8, 1'b0);
    chk("reset_sum", sum8, 8'h00);
    chk("reset_cout", cout8, 1'b0);
    chk("reset_ovf", ovf8, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table of independent operations, each starting from IDLE
    for (int k = 0; k < 10; k++) begin
      launch(0, tbl[k].s, {24'b0, tbl[k].x}, {24'b0, tbl[k].y});
      chk($sformatf("tbl_busy_%0d", k), busy8, 1'b1);
      wait_done(0, cnt);
      chk($sformatf("tbl_latency_%0d", k), cnt, 8);
      chk($sformatf("tbl_sum_%0d", k), sum8, tbl[k].e_sum);
      chk($sformatf("tbl_cout_%0d", k), cout8, tbl[k].e_cout);
      chk($sformatf("tbl_ovf_%0d", k), ovf8, tbl[k].e_ovf);
      chk($sformatf("tbl_busy_low_%0d", k), busy8, 1'b0);
      $display("tbl op %0d sub=%0d a=0x%0h b=0x%0h -> sum=0x%0h cout=%0d ovf=%0d cycles=%0d",
               k, tbl[k].s, tbl[k].x, tbl[k].y, sum8, cout8, ovf8, cnt);
      @(negedge clk);
      chk($sformatf("tbl_done_pulse_%0d", k), done8, 1'b0);
      chk($sformatf("tbl_sum_hold_%0d", k), sum8, tbl[k].e_sum);
    end

    // Start while busy is ignored; result from the first operands only
    launch(0, 1'b1, 32'h10, 32'h20);
    repeat (2) @(negedge clk);
    start_w[0] = 1'b1;
    sub_w[0]   = 1'b0;
    a_w[0]     = 32'hFF;
    b_w[0]     = 32'hFF;
    @(negedge clk);
    start_w[0] = 1'b0;
    chk("ignore_sum_hold_in_run", sum8, 8'h80);
    chk("ignore_busy", busy8, 1'b1);
    wait_done(0, extra);
    chk("ignore_latency", 3 + extra, 8);
    chk("ignore_sum", sum8, 8'hF0);
    chk("ignore_cout", cout8, 1'b0);
    chk("ignore_ovf", ovf8, 1'b0);
    $display("ignore op sub=1 a=0x10 b=0x20 -> sum=0x%0h cout=%0d ovf=%0d cycles=%0d",
             sum8, cout8, ovf8, 3 + extra);
    @(negedge clk);

    // ena low for 5 cycles mid-run, then again while done is high
    launch(0, 1'b0, 32'h5A, 32'h3C);
    repeat (2) @(negedge clk);
    ena = 1'b0;
    repeat (5) @(negedge clk);
    chk("ena_busy_frozen", busy8, 1'b1);
    ena = 1'b1;
    wait_done(0, extra);
    chk("ena_latency", 7 + extra, 13);
    ena = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("ena_done_stretch_%0d", k), done8, 1'b1);
    end
    ena = 1'b1;
    @(negedge clk);
    chk("ena_done_drop", done8, 1'b0);
    chk("ena_sum", sum8, 8'h96);
    chk("ena_cout", cout8, 1'b0);
    chk("ena_ovf", ovf8, 1'b1);
    $display("ena op sub=0 a=0x5A b=0x3C -> sum=0x%0h cout=%0d ovf=%0d cycles=%0d",
             sum8, cout8, ovf8, 7 + extra);

    // Reset at bit 4 aborts the operation
    launch(0, 1'b0, 32'hFF, 32'hFF);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy8, 1'b0);
    chk("abort_done", done8, 1'b0);
    chk("abort_sum", sum8, 8'h00);
    chk("abort_cout", cout8, 1'b0);
    chk("abort_ovf", ovf8, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done8 || busy8) seen++;
    end
    chk("abort_no_done", seen, 0);
    launch(0, 1'b0, 32'h01, 32'h01);
    wait_done(0, cnt);
    chk("after_abort_latency", cnt, 8);
    chk("after_abort_sum", sum8, 8'h02);
    chk("after_abort_cout", cout8, 1'b0);
    chk("after_abort_ovf", ovf8, 1'b0);
    $display("post-reset op sub=0 a=0x01 b=0x01 -> sum=0x%0h cycles=%0d", sum8, cnt);
    @(negedge clk);

    // Back-to-back chains
    chain_q.delete();
    chain_q.push_back('{1'b0, 32'h5A, 32'h3C});
    chain_q.push_back('{1'b1, 32'h80, 32'h01});
    chain_q.push_back('{1'b1, 32'h10, 32'h20});
    chain_q.push_back('{1'b0, 32'hFF, 32'h01});
    run_chain(0);

    chain_q.delete();
    for (int s = 0; s < 2; s++)
      for (int x = 0; x < 4; x++)
        for (int y = 0; y < 4; y++) begin
          op.s = 1'(s);
          op.x = 32'(x);
          op.y = 32'(y);
          chain_q.push_back(op);
        end
    run_chain(1);

    chain_q.delete();
    chain_q.push_back('{1'b0, 32'h7FFFFFFF, 32'h00000001});
    chain_q.push_back('{1'b1, 32'h80000000, 32'h00000001});
    chain_q.push_back('{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF});
    chain_q.push_back('{1'b1, 32'h00000000, 32'h00000001});
    for (int k = 0; k < 12; k++) begin
      op.s = 1'($urandom_range(0, 1));
      op.x = $urandom;
      op.y = $urandom;
      chain_q.push_back(op);
    end
    run_chain(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
